// File: rtl/fifo_line_reader_if.sv
// Handshake bundle between the line reader, the upstream pixel FIFO read port and the output stream.
// master: the reader itself; slave: the FIFO/sink environment around it.
interface fifo_line_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_eol;

    modport master (
        output fifo_rd_en, m_valid, m_data, m_eol,
        input  fifo_rd_data, fifo_rd_empty, flush, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_eol,
        output fifo_rd_data, fifo_rd_empty, flush, m_ready
    );
endinterface

// File: rtl/fifo_line_reader.sv
// Drains a latency-RD_LATENCY FIFO read port into a ready/valid pixel stream via a small skid buffer.
// Define FIFO_LINE_READER_EOL_EN to compile in the column counter that drives m_eol.
module fifo_line_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int H_ACTIVE   = 640
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_line_reader_if.master bus
);
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(RD_LATENCY + 1);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 2 || H_ACTIVE < 2 || H_ACTIVE > 4096) begin : g_param_check
            $error("fifo_line_reader: illegal RD_LATENCY or H_ACTIVE");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [RD_LATENCY-1:0] stage_reg;
    logic [RD_LATENCY-1:0] stage_next;
    logic [LW-1:0]         inflight;
    logic [CW:0]           occupancy;
    logic                  valid;
    logic                  push;
    logic                  pop;
    logic                  rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + LW'(stage_reg[i]);
        end
    end

    assign valid = (count_reg != '0);
    assign pop   = valid & bus.m_ready;
    assign push  = stage_reg[RD_LATENCY-1] & ~bus.flush;

    // The entry leaving this cycle already counts as free space.
    assign occupancy = (CW+1)'(count_reg) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign rd_en     = rst_n & ~bus.fifo_rd_empty & ~bus.flush & (occupancy < (CW+1)'(DEPTH));

    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = rd_en;
            end else begin : g_next
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg  <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (bus.flush) begin
            stage_reg  <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            stage_reg <= stage_next;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        end
    end

    // Storage needs no reset: only entries below count_reg are ever presented.
    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= bus.fifo_rd_data;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = valid ? mem_reg[rd_ptr_reg] : '0;

`ifdef FIFO_LINE_READER_EOL_EN
    localparam int XW = $clog2(H_ACTIVE);
    logic [XW-1:0] col_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
        end else if (bus.flush) begin
            col_reg <= '0;
        end else if (pop) begin
            col_reg <= (col_reg == XW'(H_ACTIVE - 1)) ? '0 : col_reg + 1'b1;
        end
    end

    assign bus.m_eol = valid & (col_reg == XW'(H_ACTIVE - 1));
`else
    assign bus.m_eol = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_line_reader.sv
// Bench for fifo_line_reader: a modelled latency-L FIFO feeds the DUT; a queue-based buffer model checks every cycle.
`timescale 1ns/1ps
module tb_fifo_line_reader;
    localparam int DW    = 32;
    localparam int L     = 2;
    localparam int H     = 4;
    localparam int DEPTH = L + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_line_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_line_reader #(
        .DATA_WIDTH(DW),
        .RD_LATENCY(L),
        .H_ACTIVE  (H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int xfers = 0;
    int col   = 0;
    logic [DW-1:0] seq = '0;
    bit empty_force = 1'b0;

    logic [DW-1:0] src_q[$];
    int            fifo_t[$];
    logic [DW-1:0] fifo_w[$];
    int            pend_t[$];
    logic [DW-1:0] pend_w[$];
    logic [DW-1:0] buf_q[$];

    bit            smp_rd, smp_valid, smp_eol, smp_pop;
    logic [DW-1:0] smp_data;
    int            smp_cyc;

    task automatic drive_empty();
        bus.fifo_rd_empty = empty_force || (src_q.size() == 0);
    endtask

    task automatic add_words(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(seq);
            seq = seq + 1'b1;
        end
        drive_empty();
    endtask

    // One clock cycle: sample mid-cycle, check against the model, advance the model, re-drive inputs.
    task automatic cycle();
        bit exp_valid, exp_rd, exp_eol;
        int occ;
        #1;
        smp_cyc   = cyc;
        smp_rd    = bus.fifo_rd_en;
        smp_valid = bus.m_valid;
        smp_data  = bus.m_data;
        smp_eol   = bus.m_eol;
        smp_pop   = 1'b0;
        if (!rst_n) begin
            tests++;
            if ({bus.fifo_rd_en, bus.m_valid, bus.m_eol} !== 3'b000 || bus.m_data !== '0) begin
                fails++;
                $display("FAIL reset_outputs cyc=%0d got rd=%b valid=%b eol=%b data=%h, required all zero",
                         cyc, bus.fifo_rd_en, bus.m_valid, bus.m_eol, bus.m_data);
            end
            buf_q.delete(); pend_t.delete(); pend_w.delete(); col = 0;
        end else begin
            exp_valid = (buf_q.size() != 0);
            tests++;
            if (bus.m_valid !== exp_valid) begin
                fails++;
                $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, bus.m_valid, exp_valid);
            end
            if (exp_valid) begin
                tests++;
                if (bus.m_data !== buf_q[0]) begin
                    fails++;
                    $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, bus.m_data, buf_q[0]);
                end
            end
`ifdef FIFO_LINE_READER_EOL_EN
            exp_eol = exp_valid && (col == H - 1);
`else
            exp_eol = 1'b0;
`endif
            tests++;
            if (bus.m_eol !== exp_eol) begin
                fails++;
                $display("FAIL m_eol cyc=%0d got=%b exp=%b", cyc, bus.m_eol, exp_eol);
            end
            smp_pop = exp_valid && (bus.m_ready === 1'b1);
            occ     = buf_q.size() + pend_t.size() - (smp_pop ? 1 : 0);
            exp_rd  = !bus.fifo_rd_empty && !bus.flush && (occ < DEPTH);
            tests++;
            if (bus.fifo_rd_en !== exp_rd) begin
                fails++;
                $display("FAIL fifo_rd_en cyc=%0d got=%b exp=%b", cyc, bus.fifo_rd_en, exp_rd);
            end
            if (smp_pop) begin
                $display("[TB] xfer %0d cyc=%0d data=%h eol=%b", xfers, cyc, buf_q[0], exp_eol);
                void'(buf_q.pop_front());
                col = (col + 1) % H;
                xfers++;
            end
            if (smp_rd && src_q.size() != 0) begin
                fifo_t.push_back(cyc + L); fifo_w.push_back(src_q[0]);
                pend_t.push_back(cyc + L); pend_w.push_back(src_q[0]);
                void'(src_q.pop_front());
            end
            if (pend_t.size() != 0 && pend_t[0] == cyc) begin
                if (!bus.flush) buf_q.push_back(pend_w[0]);
                void'(pend_t.pop_front()); void'(pend_w.pop_front());
            end
            if (bus.flush) begin
                buf_q.delete(); pend_t.delete(); pend_w.delete(); col = 0;
            end
        end
        @(negedge clk);
        cyc++;
        while (fifo_t.size() != 0 && fifo_t[0] < cyc) begin
            void'(fifo_t.pop_front()); void'(fifo_w.pop_front());
        end
        if (fifo_t.size() != 0 && fifo_t[0] == cyc) bus.fifo_rd_data = fifo_w[0];
        else bus.fifo_rd_data = $urandom;
        drive_empty();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || buf_q.size() != 0 || pend_t.size() != 0) && n < 200) begin
            cycle();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s_drain_timeout got src=%0d buf=%0d exp empty", name, src_q.size(), buf_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_empty();
        int rd_cnt, val_cnt;
        rd_cnt = 0; val_cnt = 0;
        empty_force = 1'b1;
        bus.m_ready = 1'b1;
        add_words(16);
        for (int i = 0; i < 12; i++) begin
            cycle();
            rd_cnt  += int'(smp_rd);
            val_cnt += int'(smp_valid);
        end
        tests++;
        if (rd_cnt != 0) begin fails++; $display("FAIL empty_rd_count got=%0d exp=0", rd_cnt); end
        tests++;
        if (val_cnt != 0) begin fails++; $display("FAIL empty_valid_count got=%0d exp=0", val_cnt); end
    endtask

    task automatic test_streaming();
        int first_rd, first_val, first_x, last_x, n;
        first_rd = -1; first_val = -1; first_x = -1; last_x = -1; n = 0;
        empty_force = 1'b0;
        bus.m_ready = 1'b1;
        drive_empty();
        for (int i = 0; i < 60 && n < 16; i++) begin
            cycle();
            if (smp_rd && first_rd < 0) first_rd = smp_cyc;
            if (smp_valid && first_val < 0) first_val = smp_cyc;
            if (smp_pop) begin
                tests++;
                if (smp_data !== DW'(n)) begin
                    fails++;
                    $display("FAIL stream_data got=%h exp=%h", smp_data, DW'(n));
                end
                if (first_x < 0) first_x = smp_cyc;
                last_x = smp_cyc;
                n++;
            end
        end
        tests++;
        if (first_val - first_rd != L + 1) begin
            fails++;
            $display("FAIL stream_latency got=%0d exp=%0d", first_val - first_rd, L + 1);
        end
        tests++;
        if (n != 16) begin fails++; $display("FAIL stream_count got=%0d exp=16", n); end
        tests++;
        if (last_x - first_x != 15) begin
            fails++;
            $display("FAIL stream_contiguous got span=%0d exp=15", last_x - first_x);
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt, x0;
        bit held_valid;
        logic [DW-1:0] held;
        rd_cnt = 0; held_valid = 1'b0; held = '0;
        bus.m_ready = 1'b0;
        add_words(20);
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            cycle();
            rd_cnt += int'(smp_rd);
            if (smp_valid) begin
                if (!held_valid) begin
                    held = smp_data; held_valid = 1'b1;
                end else begin
                    tests++;
                    if (smp_data !== held) begin
                        fails++;
                        $display("FAIL bp_stable got=%h exp=%h", smp_data, held);
                    end
                end
            end
        end
        tests++;
        if (rd_cnt != DEPTH) begin fails++; $display("FAIL bp_rd_count got=%0d exp=%0d", rd_cnt, DEPTH); end
        bus.m_ready = 1'b1;
        drain("bp");
        tests++;
        if (xfers - x0 != 20) begin fails++; $display("FAIL bp_xfer_count got=%0d exp=20", xfers - x0); end
    endtask

    task automatic test_flush();
        bit found, got;
        logic [DW-1:0] next_word;
        found = 1'b0; got = 1'b0;
        bus.m_ready = 1'b0;
        add_words(10);
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (buf_q.size() == 2 && pend_t.size() >= 1) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL flush_setup got buf=%0d exp 2 buffered", buf_q.size()); end
        next_word   = src_q[0];
        bus.flush   = 1'b1;
        cycle();
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        cycle();
        tests++;
        if (smp_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b exp=0", smp_valid); end
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (smp_pop) begin
                got = 1'b1;
                tests++;
                if (smp_data !== next_word) begin
                    fails++;
                    $display("FAIL flush_next_word got=%h exp=%h", smp_data, next_word);
                end
            end
        end
        tests++;
        if (!got) begin fails++; $display("FAIL flush_no_output got=none exp=%h", next_word); end
        drain("flush");
    endtask

    task automatic test_eol();
        int k;
        bit exp_eol;
        k = 0;
        bus.m_ready = 1'b0;
        bus.flush   = 1'b1;
        cycle();
        bus.flush = 1'b0;
        add_words(12);
        for (int i = 0; i < 200 && k < 12; i++) begin
            bus.m_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (smp_pop) begin
                k++;
`ifdef FIFO_LINE_READER_EOL_EN
                exp_eol = (k % H == 0);
`else
                exp_eol = 1'b0;
`endif
                tests++;
                if (smp_eol !== exp_eol) begin
                    fails++;
                    $display("FAIL eol_transfer_%0d got=%b exp=%b", k, smp_eol, exp_eol);
                end
            end
        end
        tests++;
        if (k != 12) begin fails++; $display("FAIL eol_count got=%0d exp=12", k); end
        bus.m_ready = 1'b1;
        drain("eol");
    endtask

    task automatic test_random();
        int x0, added, n;
        x0 = xfers; added = 0;
        for (int i = 0; i < 300; i++) begin
            empty_force = ($urandom_range(0, 3) == 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(1, 3));
                add_words(n);
                added += n;
            end
            drive_empty();
            cycle();
        end
        empty_force = 1'b0;
        bus.m_ready = 1'b1;
        drive_empty();
        drain("random");
        tests++;
        if (xfers - x0 != added) begin
            fails++;
            $display("FAIL random_xfer_count got=%0d exp=%0d", xfers - x0, added);
        end
    endtask

    task automatic test_reset_midstream();
        bit got;
        logic [DW-1:0] next_word;
        got = 1'b0;
        bus.m_ready = 1'b1;
        add_words(20);
        for (int i = 0; i < 6; i++) cycle();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.fifo_rd_en, bus.m_valid, bus.m_eol} !== 3'b000 || bus.m_data !== '0) begin
            fails++;
            $display("FAIL reset_async got rd=%b valid=%b eol=%b data=%h, required all zero",
                     bus.fifo_rd_en, bus.m_valid, bus.m_eol, bus.m_data);
        end
        cycle();
        rst_n     = 1'b1;
        next_word = src_q[0];
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (smp_pop) begin
                got = 1'b1;
                tests++;
                if (smp_data !== next_word) begin
                    fails++;
                    $display("FAIL reset_next_word got=%h exp=%h", smp_data, next_word);
                end
            end
        end
        tests++;
        if (!got) begin fails++; $display("FAIL reset_no_output got=none exp=%h", next_word); end
        drain("reset");
    endtask

    initial begin
        bus.flush         = 1'b0;
        bus.m_ready       = 1'b0;
        bus.fifo_rd_empty = 1'b1;
        bus.fifo_rd_data  = '0;
        test_reset();
        test_empty();
        test_streaming();
        test_backpressure();
        test_flush();
        test_eol();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_line_reader.md
FIFO_LINE_READER -- requirements
Module: fifo_line_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and output stream data.
REQ-002 Parameter RD_LATENCY, default 1, number of cycles from an accepted FIFO read to rd_data valid; legal values 1 or 2 (2 when the FIFO output register is enabled).
REQ-003 Parameter H_ACTIVE, default 640, pixels per line; legal range 2..4096.
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port fifo_rd_en  output  1  FIFO read request.
REQ-007 Port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after an accepted read.
REQ-008 Port fifo_rd_empty  input  1  FIFO empty flag.
REQ-009 Port flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-010 Port m_valid  output  1  output stream data valid.
REQ-011 Port m_ready  input  1  downstream accept.
REQ-012 Port m_data  output  DATA_WIDTH  output stream data.
REQ-013 Port m_eol  output  1  qualifies m_data as last pixel of a line.

Function
REQ-014 An accepted read is any cycle with fifo_rd_en=1; fifo_rd_en SHALL never be 1 while fifo_rd_empty=1 or flush=1.
REQ-015 Internal elastic buffer: FIFO of depth RD_LATENCY+2 entries; occupancy plus in-flight reads (0..RD_LATENCY) SHALL never exceed the depth.
REQ-016 fifo_rd_en SHALL be 1 whenever fifo_rd_empty=0, flush=0 and (occupancy + in-flight) < depth, counting the entry popped in the same cycle as free.
REQ-017 In-flight tracking: RD_LATENCY-stage valid shift register; data presented by the FIFO SHALL be written into the buffer on the cycle its stage reaches the end.
REQ-018 m_valid=1 exactly when the buffer is non-empty; m_data = head entry; a transfer occurs when m_valid=1 and m_ready=1.
REQ-019 m_data and m_valid SHALL not change while m_valid=1 and m_ready=0.
REQ-020 Throughput: with the FIFO never empty and m_ready held 1, one transfer per cycle after initial latency of RD_LATENCY+1 cycles from first fifo_rd_en.
REQ-021 Simultaneous push and pop on a full or empty buffer SHALL both take effect with no loss or duplication.
REQ-022 Buffer pointers wrap modulo depth; occupancy counter width ceil(log2(depth+1)).
REQ-023 flush=1 SHALL empty the buffer, clear the in-flight shift register (data arriving later is dropped), reset the column counter, and force m_valid=0 in the following cycle.
REQ-024 Data order at m_data SHALL equal FIFO read order; no reordering, no duplication.

Reset
REQ-025 rst_n=0 asynchronously clears buffer occupancy, pointers, in-flight stages and column counter.
REQ-026 During and on release of reset: fifo_rd_en=0, m_valid=0, m_eol=0, m_data=0.
REQ-027 Reset mid-stream SHALL discard all data; FIFO data returned for pre-reset reads SHALL not be captured.

Configuration
REQ-028 Macro FIFO_LINE_READER_EOL_EN compiles in line tracking.
REQ-029 With FIFO_LINE_READER_EOL_EN: column counter 0..H_ACTIVE-1 increments on each transfer, wraps to 0 after H_ACTIVE-1; m_eol=1 while m_valid=1 and counter=H_ACTIVE-1.
REQ-030 Without FIFO_LINE_READER_EOL_EN: no column counter is instantiated; m_eol tied 0; all other behaviour identical.

Verification
REQ-031 Streaming: RD_LATENCY=1, FIFO preloaded 0..15, m_ready=1 -> m_data 0..15 on consecutive cycles, first m_valid 2 cycles after first fifo_rd_en.
REQ-032 Backpressure: RD_LATENCY=2, m_ready=0 for 10 cycles with FIFO non-empty -> fifo_rd_en high at most 4 cycles total, m_data stable, then m_ready=1 yields contiguous sequence, no loss.
REQ-033 Empty: fifo_rd_empty=1 throughout -> fifo_rd_en never 1, m_valid stays 0; random empty toggling -> output sequence equals input sequence.
REQ-034 Flush: flush pulsed with 2 entries buffered and 1 in flight -> m_valid=0 next cycle, dropped in-flight word never appears, next word after flush is the following FIFO word.
REQ-035 EOL (macro defined, H_ACTIVE=4): 12 transfers -> m_eol=1 on transfers 4, 8, 12 only; macro undefined -> m_eol=0 always.
REQ-036 Reset: rst_n low for 1 cycle mid-stream with m_ready=1 -> outputs 0 immediately, no pre-reset word emitted after release.
